window_row_feeder: RTL and testbench

- Producer end of the 4-pixel row-chunk stream consumed by the 4x4 sliding-window buffer.
- Walks an int8 feature map stored in a word-addressed on-chip SRAM, four pixels per 32-bit word, one vertical strip at a time.
- Emits each row chunk with a valid/ready handshake, plus strip-boundary flags so the consumer can restart its window fill at each strip.

---
 rtl/window_row_feeder_if.sv | 25 ++
 rtl/window_row_feeder.sv | 185 ++++++++++++++++++
 tb/tb_window_row_feeder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/window_row_feeder_if.sv
// Row-chunk stream from the feeder to the window buffer.
// Data and strip flags are qualified by valid_out.
interface window_row_feeder_if;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] pixels_out_chunk_bus;
  logic        first_row_out;
  logic        last_out;

  modport master (
    output valid_out,
    output pixels_out_chunk_bus,
    output first_row_out,
    output last_out,
    input  ready_in
  );

  modport slave (
    input  valid_out,
    input  pixels_out_chunk_bus,
    input  first_row_out,
    input  last_out,
    output ready_in
  );
endinterface

// File: rtl/window_row_feeder.sv
// Strip-major SRAM walker feeding 4-pixel row chunks
// to the sliding-window buffer through a 1-entry skid.
module window_row_feeder #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  window_row_feeder_if.master out
);

  localparam int WPR = IMG_W / 4;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WPR - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WPR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e            state_q;
  logic              busy_q, done_q;
  logic [ADDR_W-1:0] strip_q, addr_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;

  logic        rd_pend_q, rd_first_q, rd_last_q;
  logic        out_v_q, out_v_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_first_q, out_first_d;
  logic        out_last_q, out_last_d;
  logic        sk_v_q, sk_v_d;
  logic [31:0] sk_data_q, sk_data_d;
  logic        sk_first_q, sk_first_d;
  logic        sk_last_q, sk_last_d;

  logic hs, stall, issue;
  logic row_end, col_end, last_rd;

  assign hs      = out_v_q & out.ready_in;
  assign stall   = out_v_q & ~out.ready_in;
  // One read in flight at most lands in out or skid
  assign issue   = (state_q == S_RUN) & ~sk_v_q & ~stall;
  assign row_end = (row_q == ROW_LAST);
  assign col_end = (col_q == COL_LAST);
  assign last_rd = row_end & col_end;

  assign mem_re   = issue;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  assign out.valid_out            = out_v_q;
  assign out.pixels_out_chunk_bus = out_data_q;
  assign out.first_row_out        = out_first_q;
  assign out.last_out             = out_last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      strip_q <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            strip_q <= base_addr;
            addr_q  <= base_addr;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (row_end) begin
              row_q   <= '0;
              col_q   <= col_q + 1'b1;
              strip_q <= strip_q + 1'b1;
              addr_q  <= strip_q + 1'b1;
            end else begin
              row_q  <= row_q + 1'b1;
              addr_q <= addr_q + STEP;
            end
            if (last_rd) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (hs && out_last_q) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FIN: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    sk_v_d      = sk_v_q;
    sk_data_d   = sk_data_q;
    sk_first_d  = sk_first_q;
    sk_last_d   = sk_last_q;
    if (!out_v_q || hs) begin
      if (sk_v_q) begin
        // Skid goes first so order is preserved
        out_v_d     = 1'b1;
        out_data_d  = sk_data_q;
        out_first_d = sk_first_q;
        out_last_d  = sk_last_q;
        sk_v_d      = rd_pend_q;
        if (rd_pend_q) begin
          sk_data_d  = mem_rdata;
          sk_first_d = rd_first_q;
          sk_last_d  = rd_last_q;
        end
      end else if (rd_pend_q) begin
        out_v_d     = 1'b1;
        out_data_d  = mem_rdata;
        out_first_d = rd_first_q;
        out_last_d  = rd_last_q;
      end else begin
        out_v_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      sk_v_d     = 1'b1;
      sk_data_d  = mem_rdata;
      sk_first_d = rd_first_q;
      sk_last_d  = rd_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q   <= 1'b0;
      rd_first_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      sk_v_q      <= 1'b0;
      sk_data_q   <= '0;
      sk_first_q  <= 1'b0;
      sk_last_q   <= 1'b0;
    end else begin
      rd_pend_q   <= issue;
      rd_first_q  <= (row_q == '0);
      rd_last_q   <= last_rd;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      sk_v_q      <= sk_v_d;
      sk_data_q   <= sk_data_d;
      sk_first_q  <= sk_first_d;
      sk_last_q   <= sk_last_d;
    end
  end

endmodule

// File: tb/tb_window_row_feeder.sv
// Directed bench: 8x4 map instance plus a 4x1 map instance,
// SRAM model returns the word address (or a fixed pattern).
module tb_window_row_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        reset;
  logic        pack;

  logic        start_a, busy_a, done_a, re_a;
  logic [11:0] base_a, addr_a;
  logic [31:0] rdata_a;
  window_row_feeder_if a_if ();

  logic        start_b, busy_b, done_b, re_b;
  logic [11:0] base_b, addr_b;
  logic [31:0] rdata_b;
  window_row_feeder_if b_if ();

  window_row_feeder #(.IMG_W(8), .IMG_H(4), .ADDR_W(12)) u_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start_a),
    .base_addr (base_a),
    .busy      (busy_a),
    .done      (done_a),
    .mem_re    (re_a),
    .mem_addr  (addr_a),
    .mem_rdata (rdata_a),
    .out       (a_if.master)
  );

  window_row_feeder #(.IMG_W(4), .IMG_H(1), .ADDR_W(12)) u_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start_b),
    .base_addr (base_b),
    .busy      (busy_b),
    .done      (done_b),
    .mem_re    (re_b),
    .mem_addr  (addr_b),
    .mem_rdata (rdata_b),
    .out       (b_if.master)
  );

  always @(posedge clk) begin
    if (re_a) rdata_a <= pack ? 32'h80FF017F : {20'h0, addr_a};
    else      rdata_a <= 32'hDEADBEEF;
    if (re_b) rdata_b <= {20'h0, addr_b};
    else      rdata_b <= 32'hDEADBEEF;
  end

  logic [31:0] exp_w [8];
  logic [11:0] exp_a [8];
  logic [31:0] last_data;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high, 1: stall pattern, 2: start re-pulsed
  task automatic run_a(input int mode, input logic [11:0] b);
    int          idx;
    int          dones;
    logic        fin;
    logic        ps;
    logic [31:0] pd;
    logic        vld;
    logic        rdy;
    idx = 0; dones = 0; fin = 1'b0; ps = 1'b0; pd = '0;
    @(negedge clk);
    start_a = 1'b1;
    base_a = b;
    a_if.ready_in = 1'b1;
    for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
      @(negedge clk);
      start_a = (mode == 2) && (cyc == 3 || cyc == 5);
      base_a = (mode == 2) ? 12'h555 : b;
      if (mode == 1)
        a_if.ready_in = !((cyc >= 2 && cyc <= 4) ||
                          (cyc > 4 && (cyc % 2) == 1));
      else
        a_if.ready_in = 1'b1;
      #1;
      vld = a_if.valid_out;
      rdy = a_if.ready_in;
      if (ps) begin
        chk("hold_valid", 32'(vld), 32'd1);
        chk("hold_data", a_if.pixels_out_chunk_bus, pd);
      end
      if (vld && !rdy) chk("re_in_stall", 32'(re_a), 32'd0);
      if (vld && rdy) begin
        chk("chunk_data", a_if.pixels_out_chunk_bus, exp_w[idx % 8]);
        chk("chunk_first", 32'(a_if.first_row_out),
            32'(idx == 0 || idx == 4));
        chk("chunk_last", 32'(a_if.last_out), 32'(idx == 7));
        last_data = a_if.pixels_out_chunk_bus;
        idx++;
      end
      if (done_a) begin
        dones++;
        fin = 1'b1;
      end
      ps = vld && !rdy;
      pd = a_if.pixels_out_chunk_bus;
    end
    chk("chunk_count", 32'(idx), 32'd8);
    chk("done_seen", 32'(dones), 32'd1);
    @(negedge clk);
    start_a = 1'b0;
    #1;
    chk("done_one_cycle", 32'(done_a), 32'd0);
    chk("busy_after", 32'(busy_a), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    pack = 1'b0;
    start_a = 1'b0;
    base_a = '0;
    start_b = 1'b0;
    base_b = '0;
    a_if.ready_in = 1'b1;
    b_if.ready_in = 1'b1;
    last_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid_a", 32'(a_if.valid_out), 32'd0);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_re_a", 32'(re_a), 32'd0);
    chk("rst_valid_b", 32'(b_if.valid_out), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);

    // Exact cycle timing, ready held high
    exp_a = '{12'h010, 12'h012, 12'h014, 12'h016,
              12'h011, 12'h013, 12'h015, 12'h017};
    exp_w = '{32'h010, 32'h012, 32'h014, 32'h016,
              32'h011, 32'h013, 32'h015, 32'h017};
    @(negedge clk);
    start_a = 1'b1;
    base_a = 12'h010;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      start_a = 1'b0;
      #1;
      chk("t1_re", 32'(re_a), 32'(cyc < 8));
      if (cyc < 8) chk("t1_addr", 32'(addr_a), 32'(exp_a[cyc]));
      chk("t1_valid", 32'(a_if.valid_out), 32'(cyc >= 2 && cyc <= 9));
      if (cyc >= 2 && cyc <= 9) begin
        chk("t1_data", a_if.pixels_out_chunk_bus, exp_w[cyc-2]);
        chk("t1_first", 32'(a_if.first_row_out),
            32'(cyc == 2 || cyc == 6));
        chk("t1_last", 32'(a_if.last_out), 32'(cyc == 9));
      end
      chk("t1_done", 32'(done_a), 32'(cyc == 10));
      chk("t1_busy", 32'(busy_a), 32'(cyc <= 9));
    end

    // Back-pressure
    run_a(1, 12'h010);

    // Wrap at top of address space, start pulses ignored
    exp_w = '{32'hFFE, 32'h000, 32'h002, 32'h004,
              32'hFFF, 32'h001, 32'h003, 32'h005};
    run_a(2, 12'hFFE);

    // Pixel packing passes through untouched
    pack = 1'b1;
    for (int i = 0; i < 8; i++) exp_w[i] = 32'h80FF017F;
    run_a(0, 12'h020);
    pack = 1'b0;
    chk("p0", 32'(signed'(last_data[7:0])), 32'd127);
    chk("p1", 32'(signed'(last_data[15:8])), 32'd1);
    chk("p2", 32'(signed'(last_data[23:16])), 32'hFFFFFFFF);
    chk("p3", 32'(signed'(last_data[31:24])), 32'hFFFFFF80);

    // Reset while a read is returning
    @(negedge clk);
    start_a = 1'b1;
    base_a = 12'h010;
    @(negedge clk);
    start_a = 1'b0;
    #1;
    chk("rr_re", 32'(re_a), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rr_valid", 32'(a_if.valid_out), 32'd0);
    chk("rr_busy", 32'(busy_a), 32'd0);
    chk("rr_re0", 32'(re_a), 32'd0);
    @(negedge clk);
    #1;
    chk("rr_discard", 32'(a_if.valid_out), 32'd0);
    exp_w = '{32'h010, 32'h012, 32'h014, 32'h016,
              32'h011, 32'h013, 32'h015, 32'h017};
    run_a(0, 12'h010);

    // Single-chunk map
    begin
      int db;
      db = 0;
      @(negedge clk);
      start_b = 1'b1;
      base_b = 12'h123;
      for (int cyc = 0; cyc < 6; cyc++) begin
        @(negedge clk);
        start_b = 1'b0;
        #1;
        chk("b_re", 32'(re_b), 32'(cyc == 0));
        if (cyc == 0) chk("b_addr", 32'(addr_b), 32'h123);
        chk("b_valid", 32'(b_if.valid_out), 32'(cyc == 2));
        if (cyc == 2) begin
          chk("b_data", b_if.pixels_out_chunk_bus, 32'h123);
          chk("b_first", 32'(b_if.first_row_out), 32'd1);
          chk("b_last", 32'(b_if.last_out), 32'd1);
        end
        chk("b_busy", 32'(busy_b), 32'(cyc <= 2));
        if (done_b) db++;
      end
      chk("b_done_once", 32'(db), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
